tdm_demux2: RTL

- Two-channel time-division demultiplexer: the receive-side counterpart of the team's 2:1 selector, which interleaves channels A and B onto one wire.
- Accepts a serial word stream where a frame-sync flag marks the channel-A slot.
- Routes each word to a registered OUT_A or OUT_B holding register with per-channel valid pulses.
- Tracks frame lock and counts sync errors; sits between the link input and downstream per-channel consumers.

---
 rtl/tdm_pkg.sv | 12 +
 rtl/sat_counter.sv | 32 +++
 rtl/tdm_demux2.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared types and defaults for the two-channel TDM demultiplexer.
package tdm_pkg;

  typedef enum logic [1:0] {
    StHunt = 2'd0,
    StExpA = 2'd1,
    StExpB = 2'd2
  } tdm_state_e;

  localparam int unsigned DefErrW = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones until reset.
module sat_counter
  import tdm_pkg::*;
#(
  parameter int unsigned ERR_W = DefErrW
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INC,
  output logic [ERR_W-1:0] CNT
);

  logic [ERR_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (INC && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CNT = cnt_q;

endmodule

// File: rtl/tdm_demux2.sv
// Two-channel TDM demultiplexer: FS marks the channel-A slot, words are routed to
// registered A/B holding outputs with per-channel valid pulses, lock tracking and error count.
module tdm_demux2
  import tdm_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter bit          REQ_FS = 1'b1,
  parameter int unsigned ERR_W  = DefErrW
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [W-1:0]     DIN,
  input  logic             DIN_VALID,
  input  logic             FS,
  output logic [W-1:0]     OUT_A,
  output logic [W-1:0]     OUT_B,
  output logic             VALID_A,
  output logic             VALID_B,
  output logic             PAIR_VALID,
  output logic             LOCKED,
  output logic             SYNC_ERR,
  output logic [ERR_W-1:0] ERR_CNT
);

  tdm_state_e state_d, state_q;

  logic [W-1:0] out_a_d, out_a_q;
  logic [W-1:0] out_b_d, out_b_q;
  logic         valid_a_d, valid_a_q;
  logic         valid_b_d, valid_b_q;
  logic         pair_valid_d, pair_valid_q;
  logic         locked_d, locked_q;
  logic         sync_err_d, sync_err_q;

  // State register plus the registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StHunt;
      out_a_q      <= '0;
      out_b_q      <= '0;
      valid_a_q    <= 1'b0;
      valid_b_q    <= 1'b0;
      pair_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
      valid_a_q    <= valid_a_d;
      valid_b_q    <= valid_b_d;
      pair_valid_q <= pair_valid_d;
      locked_q     <= locked_d;
      sync_err_q   <= sync_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (DIN_VALID) begin
      unique case (state_q)
        StHunt: if (FS) state_d = StExpB;
        StExpB: if (!FS) state_d = StExpA;
        StExpA: begin
          if (FS || !REQ_FS) begin
            state_d = StExpB;
          end else begin
            state_d = StHunt;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  // Output / capture logic; pulses default low so idle cycles clear them
  always_comb begin
    out_a_d      = out_a_q;
    out_b_d      = out_b_q;
    valid_a_d    = 1'b0;
    valid_b_d    = 1'b0;
    pair_valid_d = 1'b0;
    locked_d     = locked_q;
    sync_err_d   = 1'b0;
    if (DIN_VALID) begin
      unique case (state_q)
        StHunt: begin
          if (FS) begin
            out_a_d   = DIN;
            valid_a_d = 1'b1;
            locked_d  = 1'b1;
          end
        end
        StExpB: begin
          if (FS) begin
            // Early frame: abandon the partial frame, restart it with this A word
            sync_err_d = 1'b1;
            out_a_d    = DIN;
            valid_a_d  = 1'b1;
          end else begin
            out_b_d      = DIN;
            valid_b_d    = 1'b1;
            pair_valid_d = 1'b1;
          end
        end
        StExpA: begin
          if (FS || !REQ_FS) begin
            out_a_d   = DIN;
            valid_a_d = 1'b1;
          end else begin
            sync_err_d = 1'b1;
            locked_d   = 1'b0;
          end
        end
        default: begin
          locked_d = 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .ERR_W(ERR_W)
  ) u_err_cnt (
    .CLK(CLK),
    .RST(RST),
    .INC(sync_err_d),
    .CNT(ERR_CNT)
  );

  assign OUT_A      = out_a_q;
  assign OUT_B      = out_b_q;
  assign VALID_A    = valid_a_q;
  assign VALID_B    = valid_b_q;
  assign PAIR_VALID = pair_valid_q;
  assign LOCKED     = locked_q;
  assign SYNC_ERR   = sync_err_q;

endmodule
